// File: rtl/memory_group_pipelined.sv
// memory_group_pipelined: pipelined byte-banked data memory for the load/store unit.
// NUM_BANKS byte-wide banks are accessed by rotation, so any size up to the bank
// count is served in one cycle. The response is registered one cycle after accept.
// Optional feature macro: MEMGRP_MISALIGN_EN. When it is defined, misaligned and
// row-spanning accesses are allowed. When it is undefined, they report an error.
module memory_group_pipelined #(
  parameter int NUM_BANKS  = 4,
  parameter int BANK_DEPTH = 4096,
  localparam int DATA_WIDTH = 8 * NUM_BANKS,
  localparam int AW = $clog2(NUM_BANKS * BANK_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [AW-1:0]         req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int BW        = $clog2(NUM_BANKS);
  localparam int RW        = $clog2(BANK_DEPTH);
  localparam int MEM_BYTES = NUM_BANKS * BANK_DEPTH;

  logic                  accept_s;
  logic [3:0]            bytes_s;
  logic [BW-1:0]         base_s;
  logic [RW-1:0]         row_s;
  logic [AW:0]           end_addr_s;
  logic                  size_err_s;
  logic                  range_err_s;
  logic                  align_err_s;
  logic                  err_s;
  logic [BW-1:0]         off_s     [NUM_BANKS];
  logic                  used_s    [NUM_BANKS];
  logic [RW-1:0]         row_sel_s [NUM_BANKS];
  logic [7:0]            wbyte_s   [NUM_BANKS];
  logic                  we_s      [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_dout_s;
`ifdef MEMGRP_MISALIGN_EN
  logic [RW-1:0]         row_inc_s;
`endif

  logic                  rsp_valid_r;
  logic                  err_r;
  logic                  load_r;
  logic                  uns_r;
  logic [1:0]            size_r;
  logic [BW-1:0]         base_r;

  logic [3:0]            rbytes_s;
  logic [BW-1:0]         lane_s;
  logic [DATA_WIDTH-1:0] raw_s;
  logic [DATA_WIDTH-1:0] ext_s;
  logic                  sign_s;
  logic                  fill_s;

  assign req_ready = !rsp_valid_r || rsp_ready;
  assign accept_s  = req_valid && req_ready;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = err_r;

  // Request decode: size, bank base, row, error classification
  always_comb begin
    bytes_s     = 4'd1 << req_size;
    base_s      = req_addr[BW-1:0];
    row_s       = req_addr[AW-1:BW];
    end_addr_s  = {1'b0, req_addr} + {{(AW-3){1'b0}}, bytes_s};
    size_err_s  = int'(bytes_s) > NUM_BANKS;
    range_err_s = end_addr_s > (AW+1)'(MEM_BYTES);
    align_err_s = (req_addr[3:0] & (bytes_s - 4'd1)) != 4'd0;
`ifdef MEMGRP_MISALIGN_EN
    row_inc_s   = row_s + {{(RW-1){1'b0}}, 1'b1};
    err_s       = size_err_s || range_err_s;
`else
    err_s       = size_err_s || range_err_s || align_err_s;
`endif
  end

  // Per-bank lane offset, row select, write byte and write enable
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      off_s[b]  = BW'(b) - base_s;
      used_s[b] = 4'(off_s[b]) < bytes_s;
`ifdef MEMGRP_MISALIGN_EN
      // banks below the base wrap into the next row
      if (BW'(b) < base_s) begin
        row_sel_s[b] = row_inc_s;
      end else begin
        row_sel_s[b] = row_s;
      end
`else
      row_sel_s[b] = row_s;
`endif
      wbyte_s[b] = req_wdata[{off_s[b], 3'b000} +: 8];
      we_s[b]    = accept_s && req_we && !err_s && used_s[b];
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [7:0] mem_r [BANK_DEPTH];
    logic [7:0] dout_r;

    // Byte store into this bank; the array is not reset so contents survive rst_n
    always_ff @(posedge clk) begin
      if (we_s[g]) begin
        mem_r[row_sel_s[g]] <= wbyte_s[g];
      end
    end

    // Bank output register, refreshed only when a request is accepted
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_r <= 8'd0;
      end else if (accept_s) begin
        dout_r <= mem_r[row_sel_s[g]];
      end
    end

    assign bank_dout_s[8*g +: 8] = dout_r;
  end

  // Response state: valid, error and the access attributes needed to rebuild data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      err_r       <= 1'b0;
      load_r      <= 1'b0;
      uns_r       <= 1'b0;
      size_r      <= 2'd0;
      base_r      <= '0;
    end else if (accept_s) begin
      rsp_valid_r <= 1'b1;
      err_r       <= err_s;
      load_r      <= !req_we;
      uns_r       <= req_unsigned;
      size_r      <= req_size;
      base_r      <= base_s;
    end else if (rsp_ready) begin
      rsp_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end
  end

  // Load data: rotate bank outputs LSB-first, then sign/zero extend
  always_comb begin
    rbytes_s = 4'd1 << size_r;
    raw_s    = '0;
    ext_s    = '0;
    sign_s   = 1'b0;
    lane_s   = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      lane_s = BW'(k) + base_r;
      raw_s[8*k +: 8] = bank_dout_s[{lane_s, 3'b000} +: 8];
      if (4'(k) == rbytes_s - 4'd1) begin
        sign_s = raw_s[8*k + 7];
      end else begin
        sign_s = sign_s;
      end
    end
    fill_s = !uns_r && sign_s;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (4'(k) < rbytes_s) begin
        ext_s[8*k +: 8] = raw_s[8*k +: 8];
      end else begin
        ext_s[8*k +: 8] = {8{fill_s}};
      end
    end
    if (load_r && !err_r) begin
      rsp_rdata = ext_s;
    end else begin
      rsp_rdata = '0;
    end
  end

endmodule

// File: tb/tb_memory_group_pipelined.sv
// Scoreboard bench for memory_group_pipelined (NUM_BANKS=4, BANK_DEPTH=4096).
module tb_memory_group_pipelined;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct {
    logic        err;
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  time  hs_times[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  memory_group_pipelined #(.NUM_BANKS(4), .BANK_DEPTH(4096)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [13:0] addr, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_data,
                       input string tag, output int waited);
    exp_t e;
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    waited = 0;
    #1;
    while (!req_ready && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    check({tag, "_accept"}, {31'd0, req_ready}, 32'd1);
    if (req_ready) begin
      e.err = e_err; e.data = e_data; e.tag = tag;
      exp_q.push_back(e);
      @(posedge clk);
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain", exp_q.size(), 32'd0);
  endtask

  // Monitor: compares each handshaken response against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (rst_n && rsp_valid && rsp_ready) begin
        hs_times.push_back($time);
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check({e.tag, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
          check({e.tag, "_rdata"}, rsp_rdata, e.data);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 14'd0; req_wdata = 32'd0; rsp_ready = 1'b1;

    // Reset state
    @(negedge clk); #1;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    check("rst_rsp_rdata", rsp_rdata,          32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Word store then extended loads
    issue(1'b1, 2'd2, 1'b0, 14'h10, 32'h8899AABB, 1'b0, 32'h0, "sw_10", w);
    issue(1'b0, 2'd2, 1'b0, 14'h10, 32'h0, 1'b0, 32'h8899AABB, "lw_10", w);
    issue(1'b0, 2'd0, 1'b0, 14'h10, 32'h0, 1'b0, 32'hFFFFFFBB, "lb_10", w);
    issue(1'b0, 2'd0, 1'b1, 14'h10, 32'h0, 1'b0, 32'h000000BB, "lbu_10", w);
    issue(1'b0, 2'd1, 1'b0, 14'h12, 32'h0, 1'b0, 32'hFFFF8899, "lh_12", w);
    issue(1'b0, 2'd1, 1'b1, 14'h12, 32'h0, 1'b0, 32'h00008899, "lhu_12", w);

    // Misaligned store across a row boundary
    issue(1'b1, 2'd2, 1'b0, 14'h20, 32'h0, 1'b0, 32'h0, "sw_20_zero", w);
    issue(1'b1, 2'd2, 1'b0, 14'h24, 32'h0, 1'b0, 32'h0, "sw_24_zero", w);
`ifdef MEMGRP_MISALIGN_EN
    issue(1'b1, 2'd2, 1'b0, 14'h21, 32'hDEADBEEF, 1'b0, 32'h0, "sw_21", w);
    issue(1'b0, 2'd2, 1'b0, 14'h20, 32'h0, 1'b0, 32'hADBEEF00, "lw_20", w);
    issue(1'b0, 2'd0, 1'b1, 14'h24, 32'h0, 1'b0, 32'h000000DE, "lbu_24", w);
    issue(1'b0, 2'd2, 1'b0, 14'h21, 32'h0, 1'b0, 32'hDEADBEEF, "lw_21", w);
    issue(1'b0, 2'd1, 1'b0, 14'h23, 32'h0, 1'b0, 32'hFFFFDEAD, "lh_23", w);
`else
    issue(1'b1, 2'd2, 1'b0, 14'h21, 32'hDEADBEEF, 1'b1, 32'h0, "sw_21", w);
    issue(1'b0, 2'd2, 1'b0, 14'h20, 32'h0, 1'b0, 32'h00000000, "lw_20", w);
    issue(1'b0, 2'd0, 1'b1, 14'h24, 32'h0, 1'b0, 32'h00000000, "lbu_24", w);
    issue(1'b0, 2'd2, 1'b0, 14'h21, 32'h0, 1'b1, 32'h0, "lw_21", w);
    issue(1'b0, 2'd1, 1'b0, 14'h23, 32'h0, 1'b1, 32'h0, "lh_23", w);
`endif

    // Top-of-memory and size errors
    issue(1'b1, 2'd1, 1'b0, 14'h3FFE, 32'h00001234, 1'b0, 32'h0, "sh_3ffe", w);
    issue(1'b0, 2'd2, 1'b0, 14'h3FFE, 32'h0, 1'b1, 32'h0, "lw_3ffe", w);
    issue(1'b1, 2'd2, 1'b0, 14'h3FFE, 32'hFFFFFFFF, 1'b1, 32'h0, "sw_3ffe", w);
    issue(1'b0, 2'd1, 1'b1, 14'h3FFE, 32'h0, 1'b0, 32'h00001234, "lhu_3ffe", w);
    issue(1'b0, 2'd0, 1'b1, 14'h3FFF, 32'h0, 1'b0, 32'h00000012, "lbu_3fff", w);
    issue(1'b0, 2'd1, 1'b0, 14'h3FFF, 32'h0, 1'b1, 32'h0, "lh_3fff", w);
    issue(1'b0, 2'd3, 1'b0, 14'h0, 32'h0, 1'b1, 32'h0, "ld_0", w);

    // Store at T, load at T+1
    issue(1'b1, 2'd2, 1'b0, 14'h40, 32'h12345678, 1'b0, 32'h0, "sw_40", w);
    issue(1'b0, 2'd2, 1'b0, 14'h40, 32'h0, 1'b0, 32'h12345678, "lw_40", w);

    // Back-to-back stream of 8 loads
    for (int i = 0; i < 8; i++)
      issue(1'b1, 2'd2, 1'b0, 14'(16'h50 + 4*i), 32'h10000000 + 32'(i), 1'b0, 32'h0, "sw_fill", w);
    drain();
    hs_times.delete();
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 2'd2, 1'b0, 14'(16'h50 + 4*i), 32'h0, 1'b0, 32'h10000000 + 32'(i), "lw_stream", w);
      check("stream_nowait", 32'(w), 32'd0);
    end
    drain();
    check("stream_count", 32'(hs_times.size()), 32'd8);
    for (int i = 1; i < 8 && i < hs_times.size(); i++)
      check("stream_spacing", 32'(hs_times[i] - hs_times[i-1]), 32'd10);

    // Stalled response holds while a new request waits
    rsp_ready = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 14'h50, 32'h0, 1'b0, 32'h10000000, "lw_stall0", w);
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 14'h54; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
      check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_rsp_rdata", rsp_rdata, 32'h10000000);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 14'h54, 32'h0, 1'b0, 32'h10000001, "lw_stall1", w);
    issue(1'b0, 2'd2, 1'b0, 14'h58, 32'h0, 1'b0, 32'h10000002, "lw_stall2", w);
    drain();

    // Asynchronous reset drops a pending response; memory persists
    rsp_ready = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 14'h3FFE, 32'h0, 1'b1, 32'h0, "lw_prerst", w);
    #1;
    check("prerst_rsp_err", {31'd0, rsp_err}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("arst_rsp_err",   {31'd0, rsp_err},   32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    issue(1'b0, 2'd2, 1'b0, 14'h40, 32'h0, 1'b0, 32'h12345678, "lw_postrst40", w);
    issue(1'b0, 2'd2, 1'b0, 14'h10, 32'h0, 1'b0, 32'h8899AABB, "lw_postrst10", w);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
